// File: rtl/fir_pkg.sv
// Shared constants and sample type for the FIR output decimator.
package fir_pkg;

  localparam int unsigned FIR_DATA_W     = 16;
  localparam int unsigned FIR_DECIM_LOG2 = 2;
  localparam int unsigned FIR_FIFO_AW    = 3;
  localparam int unsigned DECIM          = 1 << FIR_DECIM_LOG2;

  typedef logic signed [FIR_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous show-ahead FIFO; head word is read combinationally from the array.
module fir_sample_fifo #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_pop_c;
  logic         do_push_c;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level     = wr_ptr - rd_ptr;
  assign rdata     = mem[rd_ptr[AW-1:0]];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_output_decimator.sv
// Power-of-two decimator for the FIR output stream, buffered by a show-ahead FIFO.
// Define FIR_DECIM_AVG_EN to average each group instead of picking its last sample.
module fir_output_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W     = FIR_DATA_W,
  parameter int unsigned DECIM_LOG2 = FIR_DECIM_LOG2,
  parameter int unsigned FIFO_AW    = FIR_FIFO_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [FIFO_AW:0]         fifo_level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  logic [DECIM_LOG2-1:0]     phase;
  logic                      dec_valid;
  logic signed [DATA_W-1:0]  dec_data;
  logic signed [DATA_W-1:0]  dec_nxt_c;
  logic                      dec_evt_c;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop_c;
  logic                      ovf_set_c;

  assign dec_evt_c = in_valid & (&phase);

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [ACC_W:0]   rnd_c;

  // Round half up before the arithmetic shift; the mean always fits DATA_W.
  assign sum_c     = acc + ACC_W'(in_data);
  assign rnd_c     = (ACC_W+1)'(sum_c) + (ACC_W+1)'(1 << (DECIM_LOG2-1));
  assign dec_nxt_c = DATA_W'(rnd_c >>> DECIM_LOG2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= dec_evt_c ? '0 : sum_c;
    end
  end
`else
  assign dec_nxt_c = in_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
    end else begin
      dec_valid <= dec_evt_c;
      if (in_valid)  phase    <= phase + DECIM_LOG2'(1);
      if (dec_evt_c) dec_data <= dec_nxt_c;
    end
  end

  assign pop_c     = out_valid & out_ready;
  assign ovf_set_c = dec_valid & fifo_full & ~pop_c;

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set_c) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  fir_sample_fifo #(
    .W  (DATA_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dec_valid),
    .pop   (pop_c),
    .wdata (dec_data),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = ~fifo_empty;

endmodule

// File: doc/fir_output_decimator.md
Name: fir_output_decimator

Overview:
- Sits directly downstream of the 10th-order FIR filter.
- Consumes its 16-bit signed output stream and decimates it by a power-of-two factor.
- Buffers decimated samples in a small show-ahead FIFO with a valid/ready handshake toward the next consumer (DAC or serializer).
- Reports FIFO occupancy and a sticky overflow flag when the consumer falls behind.

Parameters:
- DATA_W, 16: sample width, signed two's complement; matches FIR y.
- DECIM_LOG2, 2: decimation factor = 2**DECIM_LOG2; legal range 1..6.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW (8 entries).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (reset==0 clears all state).
- in_valid  in  1  in_data holds a new FIR output sample this cycle.
- in_data  in  DATA_W  FIR output sample (signed).
- out_valid  out  1  FIFO non-empty; out_data valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  DATA_W  FIFO head sample (signed).
- fifo_level  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.
- overflow  out  1  sticky: a decimated sample was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset values (while reset==0, asynchronously):
  - out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - Phase counter=0, accumulator=0, dec_valid=0.
  - FIFO read and write pointers=0.
- Phase counter:
  - Width DECIM_LOG2; increments on each clk edge with in_valid=1; wraps from DECIM-1 to 0.
  - Holds when in_valid=0.
- Decimation event: in_valid=1 and phase==DECIM-1 at an edge.
  - Loads dec_data and sets dec_valid=1 for exactly one cycle.
  - Otherwise dec_valid=0 next cycle.
- FIFO write: on the edge after a decimation event (dec_valid=1).
  - Written if not full, or if full and a pop occurs on the same edge.
  - Otherwise the sample is dropped and overflow is set.
- FIFO read (pop): on any edge with out_valid=1 and out_ready=1. Pointers advance by one.
- Show-ahead output:
  - out_data = mem[rd_ptr], combinational from the register array.
  - out_valid = (fifo_level != 0).
- Latency: decimation edge E0 -> FIFO write E1 -> out_valid high after E1 (2 edges). No empty-FIFO bypass.
- Simultaneous events:
  - Push and pop when empty: push accepted, level 0->1, out_valid rises next cycle.
  - Push and pop when full: both accepted, level stays full.
  - Push and pop otherwise: level unchanged.
- Pointers: FIFO_AW+1 bits with a wrap bit.
  - full = (addresses equal) and (wrap bits differ).
  - empty = pointers equal.
- overflow: set on a dropped sample; cleared by clr_ovf=1. If set and clear occur on the same edge, set wins.
- out_ready while empty: ignored; no pointer movement.
- in_valid gaps: do not reset phase or the accumulator.
- Reset asserted mid-operation: all state cleared, including any partially accumulated group; buffered FIFO contents are discarded.

Optional Feature:
- Macro: FIR_DECIM_AVG_EN.
- Defined (averaging mode):
  - Signed accumulator of DATA_W+DECIM_LOG2 bits sums the DECIM accepted samples of each group.
  - On the decimation event: dec_data = (sum_including_current + 2**(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. arithmetic shift, round-half-up.
  - Accumulator restarts from 0 at the next group.
  - Result always fits DATA_W, so no saturation is needed.
- Undefined (pick mode):
  - dec_data = in_data at the decimation event, i.e. the last sample of each group.
  - No accumulator is synthesized.

Decomposition:
- Package fir_pkg:
  - DATA_W default constant.
  - Signed sample typedef.
  - Helper constant DECIM = 1 << DECIM_LOG2.
- One natural sub-module: fir_sample_fifo.
  - Parameterized synchronous show-ahead FIFO: push/pop/full/empty/level.
  - Instantiated once; decimation logic stays in the top module.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and in_data=0x1234 -> out_valid=0, fifo_level=0, overflow=0 throughout; release reset -> phase starts at 0.
- Pick mode, DECIM=4, out_ready=1: in_data=1,2,4,8,16,32,64,128 continuous -> out_data=8 then 128; out_valid high 2 edges after the 4th and 8th input edges.
- Averaging mode, DECIM=4:
  - in_data=1,2,3,4 -> out_data=3 (10+2=12>>>2).
  - in_data=-1,-2,-3,-4 -> out_data=-2.
  - four samples of 0x7FFF -> out_data=0x7FFF.
- Backpressure: out_ready=0, feed 9 groups -> fifo_level reaches 8, 9th decimated sample dropped, overflow=1; out_ready=1 drains the first 8 in order.
- Full with simultaneous push/pop: FIFO at 8, out_ready=1 on the push edge -> level stays 8, overflow stays 0.
- Sticky clear and input gaps:
  - clr_ovf=1 on the same edge as a new drop -> overflow remains 1; clr_ovf=1 alone -> overflow=0.
  - in_valid toggling 1,0,0,1,... -> decimation counts only valid cycles.
